bash_csr_bank: RTL and testbench

//  Parametrised register bank between the bus slave port and the bash-hash core.

---
 rtl/bash_csr_bank.sv | 169 ++++++++++++++++
 tb/tb_bash_csr_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bash_csr_bank.sv
// Register bank between the bus slave port and the bash-hash core: X/L inputs,
// Y result snapshot, CTRL pulses, sticky DONE/ERR status and a level interrupt.
module bash_csr_bank #(
  parameter int XLEN    = 32,
  parameter int ADDRLEN = 8,
  parameter int X_WORDS = 32,
  parameter int Y_WORDS = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [XLEN/8-1:0]         we_i,
  input  logic [ADDRLEN-1:0]        addr_i,
  input  logic [XLEN-1:0]           wrdata_i,
  output logic [XLEN-1:0]           rddata_o,
  output logic                      rvalid_o,
  input  logic                      active_i,
  input  logic                      rdy_i,
  output logic                      prep_o,
  output logic                      start_o,
  output logic                      irq_o,
  output logic [XLEN-1:0]           l_reg_o,
  output logic [XLEN*X_WORDS-1:0]   x_reg_o,
  input  logic [XLEN*Y_WORDS-1:0]   y_reg_i
);

  localparam int BYTES    = XLEN / 8;
  localparam int Y_BASE   = X_WORDS * BYTES;
  localparam int CSR_BASE = Y_BASE + Y_WORDS * BYTES;
  localparam logic [ADDRLEN-1:0] ALIGN_MASK  = ~ADDRLEN'(BYTES - 1);
  localparam logic [ADDRLEN-1:0] L_ADDR      = ADDRLEN'(CSR_BASE);
  localparam logic [ADDRLEN-1:0] CTRL_ADDR   = ADDRLEN'(CSR_BASE + 4);
  localparam logic [ADDRLEN-1:0] STATUS_ADDR = ADDRLEN'(CSR_BASE + 8);

  logic [XLEN-1:0] x_q [X_WORDS];
  logic [XLEN-1:0] x_d [X_WORDS];
  logic [XLEN-1:0] y_q [Y_WORDS];
  logic [XLEN-1:0] y_d [Y_WORDS];
  logic [XLEN-1:0] l_q, l_d, rddata_q, rddata_d, rd_word;
  logic irq_en_q, irq_en_d, done_q, done_d, err_q, err_d, rdy_q, rdy_d;
  logic rvalid_q, rvalid_d, prep_q, prep_d, start_q, start_d, irq_q, irq_d;
  logic [ADDRLEN-1:0] addr_al;
  logic wr, rd;

  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_w,
                                                  input logic [XLEN-1:0] new_w,
                                                  input logic [BYTES-1:0] be);
    merge_bytes = old_w;
    for (int b = 0; b < BYTES; b++) begin
      if (be[b]) merge_bytes[b*8 +: 8] = new_w[b*8 +: 8];
    end
  endfunction

  assign addr_al = addr_i & ALIGN_MASK;
  assign wr      = en_i & (|we_i);
  assign rd      = en_i & ~(|we_i);

  // Read mux: status bits 0/1 are live core inputs, not stored copies.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < X_WORDS; i++) begin
      if (addr_al == ADDRLEN'(i * BYTES)) rd_word = x_q[i];
    end
    for (int k = 0; k < Y_WORDS; k++) begin
      if (addr_al == ADDRLEN'(Y_BASE + k * BYTES)) rd_word = y_q[k];
    end
    if (addr_al == L_ADDR) rd_word = l_q;
    if (addr_al == CTRL_ADDR) rd_word[2] = irq_en_q;
    if (addr_al == STATUS_ADDR) begin
      rd_word[0] = rdy_i;
      rd_word[1] = active_i;
      rd_word[8] = done_q;
      rd_word[9] = err_q;
    end
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    l_d      = l_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;
    prep_d   = 1'b0;
    start_d  = 1'b0;
    rdy_d    = rdy_i;
    rvalid_d = rd;
    rddata_d = rd ? rd_word : rddata_q;
    irq_d    = done_q & irq_en_q;

    // Status clears are applied first so a same-cycle set event overrides them.
    if (wr && addr_al == STATUS_ADDR && we_i[1]) begin
      if (wrdata_i[8]) done_d = 1'b0;
      if (wrdata_i[9]) err_d  = 1'b0;
    end

    if (wr) begin
      for (int i = 0; i < X_WORDS; i++) begin
        if (addr_al == ADDRLEN'(i * BYTES)) begin
          if (active_i) err_d = 1'b1;
          else          x_d[i] = merge_bytes(x_q[i], wrdata_i, we_i);
        end
      end
      if (addr_al == L_ADDR) begin
        if (active_i) err_d = 1'b1;
        else          l_d = merge_bytes(l_q, wrdata_i, we_i);
      end
      if (addr_al == CTRL_ADDR && we_i[0]) begin
        irq_en_d = wrdata_i[2];
        if (wrdata_i[0] && wrdata_i[1]) begin
          prep_d = 1'b1;
          err_d  = 1'b1;
        end else if (wrdata_i[1]) begin
          if (active_i) err_d = 1'b1;
          else          start_d = 1'b1;
        end else if (wrdata_i[0]) begin
          prep_d = 1'b1;
        end
      end
    end

    if (rdy_i && !rdy_q) begin
      done_d = 1'b1;
      for (int k = 0; k < Y_WORDS; k++) y_d[k] = y_reg_i[k*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < X_WORDS; i++) x_q[i] <= '0;
      for (int k = 0; k < Y_WORDS; k++) y_q[k] <= '0;
      l_q      <= '0;
      rddata_q <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      rvalid_q <= 1'b0;
      prep_q   <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      l_q      <= l_d;
      rddata_q <= rddata_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
      rvalid_q <= rvalid_d;
      prep_q   <= prep_d;
      start_q  <= start_d;
      irq_q    <= irq_d;
    end
  end

  for (genvar g = 0; g < X_WORDS; g++) begin : g_xout
    assign x_reg_o[g*XLEN +: XLEN] = x_q[g];
  end

  assign rddata_o = rddata_q;
  assign rvalid_o = rvalid_q;
  assign prep_o   = prep_q;
  assign start_o  = start_q;
  assign irq_o    = irq_q;
  assign l_reg_o  = l_q;

endmodule

// File: tb/tb_bash_csr_bank.sv
// Bench for bash_csr_bank: directed scenarios plus randomized bus/core traffic
// checked against a byte-level behavioural model of the register map.
module tb_bash_csr_bank;
  localparam int XLEN    = 32;
  localparam int ADDRLEN = 8;
  localparam int X_WORDS = 32;
  localparam int Y_WORDS = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic en, active, rdy;
  logic [3:0] we;
  logic [ADDRLEN-1:0] addr;
  logic [XLEN-1:0] wdata, rddata, l_reg;
  logic rvalid, prep, start, irq;
  logic [XLEN*X_WORDS-1:0] x_reg;
  logic [XLEN*Y_WORDS-1:0] yin;

  always #5 clk = ~clk;

  bash_csr_bank #(.XLEN(XLEN), .ADDRLEN(ADDRLEN), .X_WORDS(X_WORDS), .Y_WORDS(Y_WORDS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .we_i(we), .addr_i(addr), .wrdata_i(wdata),
    .rddata_o(rddata), .rvalid_o(rvalid), .active_i(active), .rdy_i(rdy),
    .prep_o(prep), .start_o(start), .irq_o(irq), .l_reg_o(l_reg), .x_reg_o(x_reg),
    .y_reg_i(yin)
  );

  // Behavioural model state
  logic [31:0] mx [X_WORDS];
  logic [31:0] my [Y_WORDS];
  logic [31:0] ml, last_rd;
  bit m_irq_en, m_done, m_err, m_rdy;
  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int a4;
    a4 = int'(a) & 'hFC;
    if (a4 < 128) return mx[a4/4];
    if (a4 < 192) return my[(a4-128)/4];
    case (a4)
      'hC0: return ml;
      'hC4: return {29'd0, m_irq_en, 2'b00};
      'hC8: return {22'd0, m_err, m_done, 6'd0, active, rdy};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < X_WORDS; i++) mx[i] = '0;
    for (int k = 0; k < Y_WORDS; k++) my[k] = '0;
    ml = '0; m_irq_en = 0; m_done = 0; m_err = 0; m_rdy = 0;
    last_rd = '0;
    exp_q.delete();
  endtask

  // One clock: drive the bus, advance the model, then check all outputs.
  task automatic cycle(input bit e, input logic [3:0] w, input logic [7:0] a,
                       input logic [31:0] d);
    bit wr, rd, exp_prep, exp_start, exp_irq;
    int a4, j;
    logic [31:0] e_rd;
    en = e; we = w; addr = a; wdata = d;
    wr = e && (w != 4'd0);
    rd = e && (w == 4'd0);
    if (rd) exp_q.push_back(m_read(a));
    exp_irq = m_done && m_irq_en;
    exp_prep = 0; exp_start = 0;
    a4 = int'(a) & 'hFC;
    if (wr) begin
      if (a4 < 128 || a4 == 'hC0) begin
        if (active) m_err = 1;
        else if (a4 < 128) mx[a4/4] = merge(mx[a4/4], d, w);
        else ml = merge(ml, d, w);
      end else if (a4 == 'hC4 && w[0]) begin
        m_irq_en = d[2];
        if (d[1:0] == 2'b11) begin exp_prep = 1; m_err = 1; end
        else if (d[1]) begin
          if (active) m_err = 1; else exp_start = 1;
        end else if (d[0]) exp_prep = 1;
      end else if (a4 == 'hC8 && w[1]) begin
        if (d[8]) m_done = 0;
        if (d[9]) m_err = 0;
      end
    end
    if (rdy && !m_rdy) begin
      m_done = 1;
      for (int k = 0; k < Y_WORDS; k++) my[k] = yin[k*32 +: 32];
    end
    m_rdy = rdy;
    @(posedge clk); #1;
    chk("rvalid", 32'(rvalid), 32'(rd));
    chk("prep", 32'(prep), 32'(exp_prep));
    chk("start", 32'(start), 32'(exp_start));
    chk("irq", 32'(irq), 32'(exp_irq));
    if (rd && exp_q.size() > 0) begin
      e_rd = exp_q.pop_front();
      chk("rdata", rddata, e_rd);
      last_rd = e_rd;
    end else begin
      chk("rd_hold", rddata, last_rd);
    end
    j = $urandom_range(0, X_WORDS-1);
    chk("x_reg", x_reg[j*32 +: 32], mx[j]);
    chk("l_reg", l_reg, ml);
  endtask

  task automatic idle();
    cycle(1'b0, 4'd0, 8'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 0; we = '0; addr = '0; wdata = '0;
    active = 0; rdy = 0; yin = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rddata, 32'd0);
    chk("rst_pulses", {29'd0, prep, start, irq}, 32'd0);
    chk("rst_x", x_reg[31:0], 32'd0);
    rst_n = 1'b1;

    // Reset reads
    cycle(1, 4'h0, 8'h0C, 0); chk("t1_x3", rddata, 32'd0);
    cycle(1, 4'h0, 8'hC0, 0); chk("t1_l", rddata, 32'd0);
    cycle(1, 4'h0, 8'hC8, 0); chk("t1_status", rddata, 32'd0);

    // Byte-lane writes
    cycle(1, 4'hF, 8'h14, 32'hAABBCCDD);
    cycle(1, 4'h5, 8'h14, 32'h11223344);
    cycle(1, 4'h0, 8'h14, 0);
    chk("t2_x5", rddata, 32'hAA22CC44);
    chk("t2_xreg5", x_reg[5*32 +: 32], 32'hAA22CC44);

    // Lockout while active
    active = 1;
    cycle(1, 4'hF, 8'h00, 32'h1234);
    cycle(1, 4'h0, 8'h00, 0); chk("t3_x0", rddata, 32'd0);
    cycle(1, 4'h0, 8'hC8, 0); chk("t3_status", rddata, 32'h202);
    cycle(1, 4'hF, 8'hC8, 32'h200);
    cycle(1, 4'h0, 8'hC8, 0); chk("t3_clr", rddata, 32'h002);
    active = 0;

    // Done event with Y snapshot and interrupt
    cycle(1, 4'hF, 8'hC4, 32'h4);
    for (int k = 0; k < Y_WORDS; k++) yin[k*32 +: 32] = 32'(k + 'h100);
    rdy = 1; idle();
    rdy = 0;
    for (int k = 0; k < Y_WORDS; k++) yin[k*32 +: 32] = $urandom;
    idle();
    chk("t4_irq", 32'(irq), 32'd1);
    for (int k = 0; k < Y_WORDS; k += 5) begin
      cycle(1, 4'h0, 8'(128 + 4*k), 0);
      chk("t4_y", rddata, 32'(k + 'h100));
    end
    cycle(1, 4'h0, 8'hC8, 0); chk("t4_done", rddata, 32'h100);
    cycle(1, 4'h2, 8'hC8, 32'h100);
    cycle(1, 4'h0, 8'hC8, 0); chk("t4_cleared", rddata, 32'h0);
    rdy = 1;
    cycle(1, 4'h2, 8'hC8, 32'h100);
    cycle(1, 4'h0, 8'hC8, 0); chk("t4_set_wins", rddata, 32'h101);
    rdy = 0; idle();

    // CTRL pulses
    cycle(1, 4'h1, 8'hC4, 32'h2); chk("t5_start", 32'(start), 32'd1);
    idle(); chk("t5_start_end", 32'(start), 32'd0);
    cycle(1, 4'h1, 8'hC4, 32'h3);
    chk("t5_prep", 32'(prep), 32'd1);
    chk("t5_nostart", 32'(start), 32'd0);
    cycle(1, 4'h0, 8'hC8, 0); chk("t5_err", 32'(rddata[9]), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int op;
      logic [7:0] a;
      if ($urandom_range(0, 15) == 0) rdy = ~rdy;
      active = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)
        for (int k = 0; k < Y_WORDS; k++) yin[k*32 +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0) a = 8'(8'hC0 + 4*$urandom_range(0, 3) + $urandom_range(0, 3));
      else a = 8'($urandom_range(0, 255));
      op = $urandom_range(0, 9);
      if (op < 4) cycle(1, 4'h0, a, $urandom);
      else if (op < 9) cycle(1, 4'($urandom_range(1, 15)), a, $urandom);
      else idle();
    end

    // Reset in the same cycle as a START write
    rdy = 0; active = 0;
    idle(); idle();
    en = 1; we = 4'h1; addr = 8'hC4; wdata = 32'h2;
    #2 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      en = 0; we = '0;
      chk("t6_start", 32'(start), 32'd0);
      chk("t6_rvalid", 32'(rvalid), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < X_WORDS; i++) cycle(1, 4'h0, 8'(4*i), 0);
    for (int k = 0; k < Y_WORDS; k++) cycle(1, 4'h0, 8'(128 + 4*k), 0);
    cycle(1, 4'h0, 8'hC0, 0); chk("t6_l", rddata, 32'd0);
    cycle(1, 4'h0, 8'hC4, 0); chk("t6_ctrl", rddata, 32'd0);
    cycle(1, 4'h0, 8'hC8, 0); chk("t6_status", rddata, 32'd0);
    idle(); chk("t6_no_start", 32'(start), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
